ud_counter_mc: RTL
==================

# ud_counter_mc

Multi-channel, parametrised up/down counter; the next generation of the team's single-channel up/down counter. It provides NCH independent channels, each with a programmable step, a configurable modulus, a per-channel wrap or saturate mode, and registered terminal-count and boundary flags. It serves as the shared counting resource for timer, credit and occupancy tracking logic that needs several counters with identical semantics behind one clock-enable.

## Interface
Parameters:
- NCH, 4, number of independent channels (1..32)
- WID, 16, counter width in bits per channel
- STEPW, 4, step input width; must be ≤ WID
- pMaxCnt, {WID{1'b1}}, terminal (maximum) count; modulus is pMaxCnt+1

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset; clears all state immediately on assertion
- ce  in  1  global clock enable; when low, all channel state and flags hold
- ld  in  NCH  per-channel load strobe
- cu  in  NCH  per-channel count-up request
- cd  in  NCH  per-channel count-down request
- mode  in  NCH  per-channel overflow mode: 0 = wrap, 1 = saturate
- step  in  NCH×STEPW  per-channel step magnitude
- d  in  NCH×WID  per-channel load value
- q  out  NCH×WID  per-channel count
- tc_up  out  NCH  one-cycle pulse: up count crossed pMaxCnt
- tc_dn  out  NCH  one-cycle pulse: down count crossed 0
- at_max  out  NCH  level: q == pMaxCnt
- at_zero  out  NCH  level: q == 0

## Operation
- Per-channel priority when ce=1: ld > count > hold.
- ld=1: q ← d; if d > pMaxCnt then q ← pMaxCnt. tc_up/tc_dn are 0.
- {cu,cd} = 2'b10: up by step; 2'b01: down by step; 2'b00 or 2'b11: hold, no flags.
- step values above pMaxCnt are treated as pMaxCnt. step = 0: q unchanged, no tc pulse.
- All sums use WID+1 bits internally; no silent truncation.
- Up, q + step ≤ pMaxCnt: q ← q + step.
- Up, overflow, wrap mode: q ← q + step − (pMaxCnt+1); tc_up=1.
- Up, overflow, saturate mode: q ← pMaxCnt; tc_up=1 only if q was below pMaxCnt before the step. A channel held at pMaxCnt does not re-pulse.
- Down, step ≤ q: q ← q − step.
- Down, underflow, wrap mode: q ← q + (pMaxCnt+1) − step; tc_dn=1.
- Down, underflow, saturate mode: q ← 0; tc_dn=1 only if q was nonzero before the step.
- Exact landing on pMaxCnt or 0 is not a crossing; no tc pulse.
- Channels are fully independent. There is no cross-channel carry.
- ce=0: q, at_max and at_zero hold; tc_up/tc_dn forced to 0 on the next edge.

## Timing
- Reset values: q = 0, tc_up = 0, tc_dn = 0, at_max = 0 (1 if pMaxCnt = 0), at_zero = 1.
- Latency is one cycle. Inputs sampled at edge N produce q, flags and levels at edge N.
- tc_up and tc_dn are registered and aligned with the q update that caused them. They last exactly one cycle unless the next edge causes another crossing.
- at_max and at_zero are registered alongside q, never decoded from q combinationally at the output.
- Reset asserted mid-count clears all outputs asynchronously. The first count occurs on the first edge after rst deasserts.
- mode may change at any time; it takes effect on the next counting edge.

## Configuration
- UD_COUNTER_MC_SAT_EN defined: saturate mode is available, selected per channel by mode.
- UD_COUNTER_MC_SAT_EN undefined: saturate logic is not built. The mode port remains but is ignored, and every channel wraps.

## Structure
- Package ud_counter_mc_pkg holds:
  - the mode enum: UDC_WRAP = 1'b0, UDC_SAT = 1'b1;
  - the direction enum derived from {cu,cd};
  - a function that clamps step to pMaxCnt.
- Sub-module ud_counter_chan implements one channel: the load/step/wrap/saturate datapath and its four flag registers.
- ud_counter_mc instantiates ud_counter_chan NCH times in a generate loop and handles port slicing.

## Test plan
- Reset: hold rst=0 with random inputs -> all q=0, at_zero=1, no tc. Release rst, pulse cu[0] once with step=1 -> q[0]=1 one edge later.
- Wrap up, WID=4, pMaxCnt=9, mode=0: from q=8, step 3 -> q=1 and a single-cycle tc_up. From q=7, step 2 -> q=9 with no tc_up.
- Saturate down (macro defined), mode=1: from q=2, step 5 -> q=0, tc_dn=1. Next down step -> q stays 0, tc_dn=0.
- Priority and load: ld=1, cu=1, d=12 with pMaxCnt=9 -> q=9, tc_up=0. Then cu=cd=1 for 3 cycles -> q holds at 9.
- ce gating and independence, NCH=4: channel 0 counts up, channel 1 counts down, channel 2 loads, channel 3 idles, with ce alternating. Each channel moves only on ce=1 edges, and no tc pulse occurs while ce=0.
- Macro off: mode=1 on a channel at q=9, step 1 -> q=0 and tc_up=1 (wrap behaviour).

Source files
------------

// File: rtl/ud_counter_mc_pkg.sv
// Shared types and helpers for the multi-channel up/down counter.
//   udc_mode_e      : per-channel overflow behaviour (wrap / saturate)
//   udc_dir_e       : count direction decoded from {cu, cd}
//   udc_clamp_step  : limits a step magnitude to the terminal count
// Optional feature macro: UD_COUNTER_MC_SAT_EN (enables saturate mode).
package ud_counter_mc_pkg;

    // Widest counter the clamp helper supports.
    localparam int unsigned UDC_MAXW = 64;

    typedef enum logic {
        UDC_WRAP = 1'b0,
        UDC_SAT  = 1'b1
    } udc_mode_e;

    typedef enum logic [1:0] {
        UDC_HOLD = 2'b00,
        UDC_DOWN = 2'b01,
        UDC_UP   = 2'b10,
        UDC_BOTH = 2'b11
    } udc_dir_e;

    // Steps larger than the terminal count behave as the terminal count.
    function automatic logic [UDC_MAXW-1:0] udc_clamp_step(
        input logic [UDC_MAXW-1:0] step,
        input logic [UDC_MAXW-1:0] max_cnt
    );
        return (step > max_cnt) ? max_cnt : step;
    endfunction

endpackage

// File: rtl/ud_counter_chan.sv
// One counter channel: load / step / wrap / saturate datapath with registered
// count, terminal-count pulses and boundary levels.
// Ports:
//   clk, rst (async active-low), ce (clock enable)
//   ld, cu, cd, mode, step[STEPW], d[WID]   : channel controls
//   q[WID], tc_up, tc_dn, at_max, at_zero   : registered outputs
// Optional feature macro: UD_COUNTER_MC_SAT_EN (saturate mode; wrap only otherwise).
module ud_counter_chan
    import ud_counter_mc_pkg::*;
#(
    parameter int unsigned    WID     = 16,
    parameter int unsigned    STEPW   = 4,
    parameter logic [WID-1:0] pMaxCnt = {WID{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             ld,
    input  logic             cu,
    input  logic             cd,
    input  logic             mode,
    input  logic [STEPW-1:0] step,
    input  logic [WID-1:0]   d,
    output logic [WID-1:0]   q,
    output logic             tc_up,
    output logic             tc_dn,
    output logic             at_max,
    output logic             at_zero
);

    // One extra bit so sums and modulus never truncate.
    localparam int unsigned   SW    = WID + 1;
    localparam logic [SW-1:0] MAX_X = SW'(pMaxCnt);
    localparam logic [SW-1:0] MOD_X = MAX_X + SW'(1);

    logic           sat;
    logic [WID-1:0] step_c;
    logic [SW-1:0]  q_x;
    logic [SW-1:0]  step_x;
    logic [SW-1:0]  sum_x;
    logic [SW-1:0]  wrap_up_x;
    logic [SW-1:0]  wrap_dn_x;
    logic [WID-1:0] q_nxt;
    logic           tc_up_nxt;
    logic           tc_dn_nxt;

`ifdef UD_COUNTER_MC_SAT_EN
    assign sat = (udc_mode_e'(mode) == UDC_SAT);
`else
    // Saturate logic absent: mode is accepted but has no effect.
    logic unused_mode;
    assign unused_mode = mode;
    assign sat         = 1'b0;
`endif

    assign step_c    = WID'(udc_clamp_step(UDC_MAXW'(step), UDC_MAXW'(pMaxCnt)));
    assign q_x       = SW'(q);
    assign step_x    = SW'(step_c);
    assign sum_x     = q_x + step_x;
    assign wrap_up_x = sum_x - MOD_X;
    assign wrap_dn_x = q_x + MOD_X - step_x;

    // Next count and crossing pulses; ld wins over counting, ce=0 holds.
    always_comb begin
        q_nxt     = q;
        tc_up_nxt = 1'b0;
        tc_dn_nxt = 1'b0;
        if (ce) begin
            if (ld) begin
                q_nxt = (d > pMaxCnt) ? pMaxCnt : d;
            end else begin
                case (udc_dir_e'({cu, cd}))
                    UDC_UP: begin
                        if (sum_x <= MAX_X) begin
                            q_nxt = WID'(sum_x);
                        end else if (sat) begin
                            q_nxt     = pMaxCnt;
                            tc_up_nxt = (q != pMaxCnt);
                        end else begin
                            q_nxt     = WID'(wrap_up_x);
                            tc_up_nxt = 1'b1;
                        end
                    end
                    UDC_DOWN: begin
                        if (step_x <= q_x) begin
                            q_nxt = WID'(q_x - step_x);
                        end else if (sat) begin
                            q_nxt     = '0;
                            tc_dn_nxt = (q != '0);
                        end else begin
                            q_nxt     = WID'(wrap_dn_x);
                            tc_dn_nxt = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Count and flag registers; levels are registered from the next count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q       <= '0;
            tc_up   <= 1'b0;
            tc_dn   <= 1'b0;
            at_max  <= (pMaxCnt == '0);
            at_zero <= 1'b1;
        end else begin
            q       <= q_nxt;
            tc_up   <= tc_up_nxt;
            tc_dn   <= tc_dn_nxt;
            at_max  <= (q_nxt == pMaxCnt);
            at_zero <= (q_nxt == '0);
        end
    end

endmodule

// File: rtl/ud_counter_mc.sv
// Multi-channel up/down counter: NCH independent channels behind one clock
// enable, each with programmable step, modulus pMaxCnt+1, wrap/saturate mode.
// Ports:
//   clk, rst (async active-low), ce
//   ld, cu, cd, mode [NCH]; step [NCH*STEPW]; d [NCH*WID]
//   q [NCH*WID]; tc_up, tc_dn, at_max, at_zero [NCH]
// Optional feature macro: UD_COUNTER_MC_SAT_EN (saturate mode per channel).
module ud_counter_mc
    import ud_counter_mc_pkg::*;
#(
    parameter int unsigned    NCH     = 4,
    parameter int unsigned    WID     = 16,
    parameter int unsigned    STEPW   = 4,
    parameter logic [WID-1:0] pMaxCnt = {WID{1'b1}}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic [NCH-1:0]       ld,
    input  logic [NCH-1:0]       cu,
    input  logic [NCH-1:0]       cd,
    input  logic [NCH-1:0]       mode,
    input  logic [NCH*STEPW-1:0] step,
    input  logic [NCH*WID-1:0]   d,
    output logic [NCH*WID-1:0]   q,
    output logic [NCH-1:0]       tc_up,
    output logic [NCH-1:0]       tc_dn,
    output logic [NCH-1:0]       at_max,
    output logic [NCH-1:0]       at_zero
);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        ud_counter_chan #(
            .WID     (WID),
            .STEPW   (STEPW),
            .pMaxCnt (pMaxCnt)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .ce      (ce),
            .ld      (ld[i]),
            .cu      (cu[i]),
            .cd      (cd[i]),
            .mode    (mode[i]),
            .step    (step[i*STEPW +: STEPW]),
            .d       (d[i*WID +: WID]),
            .q       (q[i*WID +: WID]),
            .tc_up   (tc_up[i]),
            .tc_dn   (tc_dn[i]),
            .at_max  (at_max[i]),
            .at_zero (at_zero[i])
        );
    end

endmodule
